// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: filtered clock strobes, 11-bit frame FSM, set-2 make/break/E0 decoding.
// Define PS2_PARITY_CHECK_EN to discard frames with a parity mismatch; otherwise the parity bit is ignored.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_released,
  output logic       key_extended,
  output logic       frame_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // state    | meaning
  // S_IDLE   | waiting for a start bit (data=0 on a strobe)
  // S_DATA   | shifting in d0..d7, LSB first
  // S_PARITY | sampling the odd-parity bit
  // S_STOP   | checking the stop bit, delivering the byte
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic            r_filt;
  logic [FW-1:0]   r_filt_cnt;
  logic            r_strobe;
  logic [7:0]      r_shift;
  logic [2:0]      r_bit_cnt;
  logic [TW-1:0]   r_wdog;
  logic            r_brk_pend;
  logic            r_ext_pend;
  logic            w_timeout;
  logic            w_parity_ok;
  logic            w_shift_en;
  logic            w_byte_done;
  logic            w_frame_bad;
  logic            w_is_reply;

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= PS2_CLK;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= PS2_DATA;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample; a 1->0 flip is a strobe.
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      r_filt     <= 1'b1;
      r_filt_cnt <= '0;
      r_strobe   <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (r_clk_s2 == r_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_filt     <= r_clk_s2;
        r_filt_cnt <= '0;
        r_strobe   <= r_filt;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end else if (r_strobe) begin
      case (r_state)
        S_IDLE:   if (!r_dat_s2) w_state_nxt = S_DATA;
        S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_shift_en  = 1'b0;
    w_byte_done = 1'b0;
    w_frame_bad = w_timeout;
    if (r_strobe) begin
      case (r_state)
        S_DATA: w_shift_en = 1'b1;
        S_STOP: begin
          if (r_dat_s2 && w_parity_ok) w_byte_done = 1'b1;
          else                         w_frame_bad = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Watchdog down-counter: the strobe cycle itself counts as the first timeout cycle.
  assign w_timeout = (r_state != S_IDLE) && !r_strobe && (r_wdog == '0);

`ifdef PS2_PARITY_CHECK_EN
  logic r_parity;

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN)                           r_parity <= 1'b0;
    else if (r_strobe && r_state == S_PARITY) r_parity <= r_dat_s2;
  end

  assign w_parity_ok = ^{r_shift, r_parity};
`else
  assign w_parity_ok = 1'b1;
`endif

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_wdog    <= '0;
    end else begin
      if (w_timeout)       r_shift <= '0;
      else if (w_shift_en) r_shift <= {r_dat_s2, r_shift[7:1]};

      if (r_strobe && r_state == S_IDLE) r_bit_cnt <= '0;
      else if (w_shift_en)               r_bit_cnt <= r_bit_cnt + 1'b1;

      if (r_strobe)                                  r_wdog <= TW'(TIMEOUT_CYCLES - 2);
      else if (r_state != S_IDLE && r_wdog != '0)    r_wdog <= r_wdog - 1'b1;
    end
  end

  assign w_is_reply = (r_shift == 8'hFA) || (r_shift == 8'hAA) || (r_shift == 8'hEE) ||
                      (r_shift == 8'hFE) || (r_shift == 8'h00) || (r_shift == 8'hFF);

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      key_code     <= 8'h00;
      key_valid    <= 1'b0;
      key_released <= 1'b0;
      key_extended <= 1'b0;
      frame_error  <= 1'b0;
      r_brk_pend   <= 1'b0;
      r_ext_pend   <= 1'b0;
    end else begin
      key_valid    <= 1'b0;
      key_released <= 1'b0;
      frame_error  <= w_frame_bad;
      if (w_frame_bad) begin
        r_brk_pend <= 1'b0;
        r_ext_pend <= 1'b0;
      end else if (w_byte_done) begin
        if (r_shift == 8'hF0) begin
          r_brk_pend <= 1'b1;
        end else if (r_shift == 8'hE0) begin
          r_ext_pend <= 1'b1;
        end else if (w_is_reply) begin
          r_brk_pend <= 1'b0;
          r_ext_pend <= 1'b0;
        end else begin
          key_code     <= r_shift;
          key_extended <= r_ext_pend;
          key_released <= r_brk_pend;
          key_valid    <= !r_brk_pend;
          r_brk_pend   <= 1'b0;
          r_ext_pend   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: bit-banged PS/2 frames with hand-computed expected events.
module tb_ps2_keyboard_rx;
  localparam int FL = 8;
  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] key_code;
  logic       key_valid, key_released, key_extended, frame_error;

  ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_dat),
    .key_code(key_code), .key_valid(key_valid), .key_released(key_released),
    .key_extended(key_extended), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  int         n_valid = 0, n_rel = 0, n_err = 0, n_overlap = 0, n_consec = 0;
  int         pulse_cyc = 0, err_cyc = 0;
  logic [7:0] cap_code = 8'h00;
  logic       cap_ext = 1'b0;
  logic       prev_pulse = 1'b0;
  always @(negedge clk) begin
    if (key_valid) n_valid++;
    if (key_released) n_rel++;
    if (key_valid || key_released) begin
      pulse_cyc = cyc;
      cap_code  = key_code;
      cap_ext   = key_extended;
    end
    if (frame_error) begin
      n_err++;
      err_cyc = cyc;
    end
    if (key_valid && key_released) n_overlap++;
    if ((key_valid || key_released) && prev_pulse) n_consec++;
    prev_pulse = key_valid || key_released;
  end

  int compared = 0, mismatched = 0;
  int last_fall = 0;
  int s_valid = 0, s_rel = 0, s_err = 0;

  task automatic snap();
    s_valid = n_valid;
    s_rel   = n_rel;
    s_err   = n_err;
  endtask

  task automatic send_bit(input logic b);
    @(posedge clk); #1 ps2_dat = b;
    repeat (10) @(posedge clk);
    #1 ps2_clk = 1'b0;
    last_fall = cyc;
    repeat (20) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ flip);
    send_bit(stop);
    repeat (5) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({key_code, key_valid, key_released, key_extended, frame_error} !== 12'h000) begin
      mismatched++;
      $display("FAIL reset_outputs: got code=%h v=%b r=%b x=%b e=%b required all 0",
               key_code, key_valid, key_released, key_extended, frame_error);
    end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_make();
    snap();
    send_frame(8'h1A, 1'b0, 1'b1);
    compared++;
    if (n_valid - s_valid !== 1) begin
      mismatched++; $display("FAIL make_count: got %0d required 1", n_valid - s_valid);
    end
    compared++;
    if (pulse_cyc - last_fall !== FL + 3) begin
      mismatched++; $display("FAIL make_latency: got %0d required %0d", pulse_cyc - last_fall, FL + 3);
    end
    compared++;
    if (cap_code !== 8'h1A || key_code !== 8'h1A) begin
      mismatched++; $display("FAIL make_code: got %h/%h required 1a", cap_code, key_code);
    end
    compared++;
    if (cap_ext !== 1'b0 || n_rel - s_rel !== 0 || n_err - s_err !== 0) begin
      mismatched++; $display("FAIL make_side: ext=%b rel=%0d err=%0d required 0/0/0", cap_ext, n_rel - s_rel, n_err - s_err);
    end
  endtask

  task automatic test_break();
    snap();
    send_frame(8'hF0, 1'b0, 1'b1);
    compared++;
    if (n_valid - s_valid + n_rel - s_rel !== 0) begin
      mismatched++; $display("FAIL break_prefix_silent: got %0d pulses required 0", n_valid - s_valid + n_rel - s_rel);
    end
    send_frame(8'h1A, 1'b0, 1'b1);
    compared++;
    if (n_rel - s_rel !== 1 || n_valid - s_valid !== 0) begin
      mismatched++; $display("FAIL break_pulse: rel=%0d valid=%0d required 1/0", n_rel - s_rel, n_valid - s_valid);
    end
    compared++;
    if (cap_code !== 8'h1A || pulse_cyc - last_fall !== FL + 3) begin
      mismatched++; $display("FAIL break_code: code=%h lat=%0d required 1a/%0d", cap_code, pulse_cyc - last_fall, FL + 3);
    end
  endtask

  task automatic test_extended();
    snap();
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    compared++;
    if (n_rel - s_rel !== 1 || n_valid - s_valid !== 0 || cap_code !== 8'h75 || cap_ext !== 1'b1) begin
      mismatched++; $display("FAIL ext_break: rel=%0d valid=%0d code=%h ext=%b required 1/0/75/1",
                             n_rel - s_rel, n_valid - s_valid, cap_code, cap_ext);
    end
    snap();
    send_frame(8'h22, 1'b0, 1'b1);
    compared++;
    if (n_valid - s_valid !== 1 || cap_code !== 8'h22 || cap_ext !== 1'b0 || key_extended !== 1'b0) begin
      mismatched++; $display("FAIL ext_cleared: valid=%0d code=%h ext=%b required 1/22/0", n_valid - s_valid, cap_code, cap_ext);
    end
  endtask

  task automatic test_parity();
    snap();
    send_frame(8'h22, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    compared++;
    if (n_err - s_err !== 1 || n_valid - s_valid !== 0) begin
      mismatched++; $display("FAIL parity_reject: err=%0d valid=%0d required 1/0", n_err - s_err, n_valid - s_valid);
    end
`else
    compared++;
    if (n_err - s_err !== 0 || n_valid - s_valid !== 1 || cap_code !== 8'h22) begin
      mismatched++; $display("FAIL parity_ignored: err=%0d valid=%0d code=%h required 0/1/22", n_err - s_err, n_valid - s_valid, cap_code);
    end
`endif
  endtask

  task automatic test_bad_stop();
    send_frame(8'hE0, 1'b0, 1'b1);
    snap();
    send_frame(8'h1C, 1'b0, 1'b0);
    compared++;
    if (n_err - s_err !== 1 || n_valid - s_valid !== 0) begin
      mismatched++; $display("FAIL bad_stop: err=%0d valid=%0d required 1/0", n_err - s_err, n_valid - s_valid);
    end
    compared++;
    if (err_cyc - last_fall !== FL + 3) begin
      mismatched++; $display("FAIL bad_stop_latency: got %0d required %0d", err_cyc - last_fall, FL + 3);
    end
    snap();
    send_frame(8'h1C, 1'b0, 1'b1);
    compared++;
    if (n_valid - s_valid !== 1 || cap_ext !== 1'b0 || cap_code !== 8'h1C) begin
      mismatched++; $display("FAIL error_clears_ext: valid=%0d ext=%b code=%h required 1/0/1c", n_valid - s_valid, cap_ext, cap_code);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] b;
    b = 8'h3B;
    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    repeat (FL + TO + 20) @(posedge clk);
    #1;
    compared++;
    if (n_err - s_err !== 1) begin
      mismatched++; $display("FAIL timeout_count: got %0d required 1", n_err - s_err);
    end
    compared++;
    if (err_cyc - last_fall !== FL + 2 + TO) begin
      mismatched++; $display("FAIL timeout_latency: got %0d required %0d", err_cyc - last_fall, FL + 2 + TO);
    end
    snap();
    send_frame(8'h3B, 1'b0, 1'b1);
    compared++;
    if (n_valid - s_valid !== 1 || cap_code !== 8'h3B || n_err - s_err !== 0) begin
      mismatched++; $display("FAIL after_timeout: valid=%0d code=%h err=%0d required 1/3b/0", n_valid - s_valid, cap_code, n_err - s_err);
    end
  endtask

  task automatic test_swallow();
    snap();
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hFA, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    compared++;
    if (n_valid - s_valid !== 1 || cap_ext !== 1'b0 || cap_code !== 8'h1C) begin
      mismatched++; $display("FAIL swallow_fa: valid=%0d ext=%b code=%h required 1/0/1c", n_valid - s_valid, cap_ext, cap_code);
    end
    snap();
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    compared++;
    if (n_valid - s_valid !== 1 || n_rel - s_rel !== 0) begin
      mismatched++; $display("FAIL swallow_aa: valid=%0d rel=%0d required 1/0", n_valid - s_valid, n_rel - s_rel);
    end
  endtask

  task automatic test_glitch();
    snap();
    @(posedge clk); #1 ps2_dat = 1'b0; ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (30) @(posedge clk);
    #1 ps2_dat = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b1);
    compared++;
    if (n_valid - s_valid !== 1 || cap_code !== 8'h1C || n_err - s_err !== 0) begin
      mismatched++; $display("FAIL glitch_ignored: valid=%0d code=%h err=%0d required 1/1c/0", n_valid - s_valid, cap_code, n_err - s_err);
    end
  endtask

  task automatic test_back_to_back();
    snap();
    for (int k = 0; k < 3; k++) send_frame(8'h1C, 1'b0, 1'b1);
    compared++;
    if (n_valid - s_valid !== 3 || n_rel - s_rel !== 0) begin
      mismatched++; $display("FAIL typematic: valid=%0d rel=%0d required 3/0", n_valid - s_valid, n_rel - s_rel);
    end
  endtask

  task automatic test_reset_midframe();
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h14, 1'b0, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    compared++;
    if ({key_code, key_valid, key_released, key_extended, frame_error} !== 12'h000) begin
      mismatched++;
      $display("FAIL midframe_reset: got code=%h v=%b r=%b x=%b e=%b required all 0",
               key_code, key_valid, key_released, key_extended, frame_error);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (TO + 50) @(posedge clk);
    snap();
    send_frame(8'h1A, 1'b0, 1'b1);
    compared++;
    if (n_valid - s_valid !== 1 || cap_code !== 8'h1A || cap_ext !== 1'b0) begin
      mismatched++; $display("FAIL after_reset: valid=%0d code=%h ext=%b required 1/1a/0", n_valid - s_valid, cap_code, cap_ext);
    end
  endtask

  task automatic test_invariants();
    compared++;
    if (n_overlap !== 0 || n_consec !== 0) begin
      mismatched++; $display("FAIL pulse_rules: overlap=%0d consecutive=%0d required 0/0", n_overlap, n_consec);
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_extended();
    test_parity();
    test_bad_stop();
    test_timeout();
    test_swallow();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
